// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 padding front end.
// Holds Keccak geometry, the SHA3-2xx/3xx/5xx rates, padding bytes,
// the padding FSM state type and a byte-count helper.
package sha3_pkg;

    localparam int unsigned STATE_SIZE    = 1600;
    localparam int unsigned Z_WIDTH       = 64;

    localparam int unsigned RATE_SHA3_224 = 1152;
    localparam int unsigned RATE_SHA3_256 = 1088;
    localparam int unsigned RATE_SHA3_384 = 832;
    localparam int unsigned RATE_SHA3_512 = 576;

    localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h06;
    localparam logic [7:0] SHA3_FINAL_BYTE  = 8'h80;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_SEND = 2'd2
    } pad_state_t;

    // Valid leading bytes of an input word: non-last words are always full,
    // out-of-range counts saturate at a full word.
    function automatic logic [3:0] eff_nbytes(input logic [3:0] nbytes, input logic last);
        if (!last || (nbytes > 4'd8)) begin
            return 4'd8;
        end
        return nbytes;
    endfunction

endpackage

// File: rtl/sha3_padding_unit_if.sv
// Message-in / block-out bundle of the padding unit.
// master: message producer and permutation side (testbench or system).
// slave : the padding unit itself.
interface sha3_padding_unit_if
    import sha3_pkg::*;
#(
    parameter int unsigned R_BLOCK_SIZE = RATE_SHA3_224
);
    logic [Z_WIDTH-1:0]      DATA_IN;
    logic                    DATA_VALID;
    logic                    DATA_LAST;
    logic [3:0]              DATA_NBYTES;
    logic                    DATA_READY;
    logic                    PERM_READY;
    logic [R_BLOCK_SIZE-1:0] OUT;
    logic                    VALID_MESSAGE_FROM_PADDING;
    logic                    LAST_MESSAGE_FROM_PADDING;

    modport master (
        output DATA_IN, DATA_VALID, DATA_LAST, DATA_NBYTES, PERM_READY,
        input  DATA_READY, OUT, VALID_MESSAGE_FROM_PADDING, LAST_MESSAGE_FROM_PADDING
    );

    modport slave (
        input  DATA_IN, DATA_VALID, DATA_LAST, DATA_NBYTES, PERM_READY,
        output DATA_READY, OUT, VALID_MESSAGE_FROM_PADDING, LAST_MESSAGE_FROM_PADDING
    );
endinterface

// File: rtl/sha3_pad_inserter.sv
// Combinational SHA-3 pad insertion on one rate block.
// i_block : block with message bytes, unused bytes zero.
// i_nbytes: number of message bytes in the block (index of the domain byte).
// o_block : block with 0x06 XOR'd at byte i_nbytes and 0x80 OR'd into the last byte.
module sha3_pad_inserter
    import sha3_pkg::*;
#(
    parameter int unsigned R_BLOCK_SIZE = RATE_SHA3_224,
    parameter int unsigned BCNT_W       = 8
) (
    input  logic [R_BLOCK_SIZE-1:0] i_block,
    input  logic [BCNT_W-1:0]       i_nbytes,
    output logic [R_BLOCK_SIZE-1:0] o_block
);
    localparam int unsigned BYTES = R_BLOCK_SIZE / 8;

    // XOR-then-OR makes the single-byte case (domain byte == last byte) 0x86.
    always_comb begin
        o_block = i_block;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (i_nbytes == BCNT_W'(k)) begin
                o_block[8*k +: 8] = o_block[8*k +: 8] ^ SHA3_DOMAIN_BYTE;
            end
        end
        o_block[R_BLOCK_SIZE-1 -: 8] = o_block[R_BLOCK_SIZE-1 -: 8] | SHA3_FINAL_BYTE;
    end
endmodule

// File: rtl/sha3_padding_unit.sv
// SHA-3 padding unit: packs 64-bit message words into rate blocks, pads the
// final block and hands blocks to the permutation with a one-cycle strobe.
// CLK : rising-edge clock.
// RST : synchronous active-high reset.
// CE  : clock enable; freezes all state and handshakes when low.
// bus : slave side of sha3_padding_unit_if (word stream in, block out).
// Byte k of a word/block sits at bits [8k+7:8k]; byte 0 is first in message order.
module sha3_padding_unit
    import sha3_pkg::*;
#(
    parameter int unsigned R_BLOCK_SIZE = RATE_SHA3_224
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CE,
    sha3_padding_unit_if.slave  bus
);
    localparam int unsigned WORDS  = R_BLOCK_SIZE / Z_WIDTH;
    localparam int unsigned BYTES  = R_BLOCK_SIZE / 8;
    localparam int unsigned CNT_W  = $clog2(WORDS + 1);
    localparam int unsigned BCNT_W = $clog2(BYTES + 1);

    pad_state_t              r_state, w_state_n;
    logic [CNT_W-1:0]        r_wcnt, w_wcnt_n;
    logic [BCNT_W-1:0]       r_bcnt, w_bcnt_n;
    logic [R_BLOCK_SIZE-1:0] r_buf, w_buf_n, w_padded;
    logic                    r_pad_pending, w_pad_pending_n;
    logic                    r_last_flag, w_last_flag_n;
    logic                    w_ready, w_xfer, w_strobe;
    logic [3:0]              w_nb;
    logic [Z_WIDTH-1:0]      w_word;
    logic [BCNT_W-1:0]       w_total;

    assign w_ready  = CE & ~RST & (r_state == S_FILL);
    assign w_xfer   = w_ready & bus.DATA_VALID;
    assign w_strobe = CE & ~RST & (r_state == S_SEND) & bus.PERM_READY;
    assign w_nb     = eff_nbytes(bus.DATA_NBYTES, bus.DATA_LAST);
    // Message bytes in the block once the current word is written.
    assign w_total  = BCNT_W'({r_wcnt, 3'b000}) + BCNT_W'(w_nb);

    // Zero the trailing invalid bytes of a final word.
    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < w_nb) begin
                w_word[8*i +: 8] = bus.DATA_IN[8*i +: 8];
            end
        end
    end

    sha3_pad_inserter #(
        .R_BLOCK_SIZE (R_BLOCK_SIZE),
        .BCNT_W       (BCNT_W)
    ) u_pad_inserter (
        .i_block  (r_buf),
        .i_nbytes (r_bcnt),
        .o_block  (w_padded)
    );

    // Next-state logic.
    always_comb begin
        w_state_n       = r_state;
        w_wcnt_n        = r_wcnt;
        w_bcnt_n        = r_bcnt;
        w_buf_n         = r_buf;
        w_pad_pending_n = r_pad_pending;
        w_last_flag_n   = r_last_flag;
        unique case (r_state)
            S_FILL: begin
                if (w_xfer) begin
                    for (int unsigned w = 0; w < WORDS; w++) begin
                        if (r_wcnt == CNT_W'(w)) begin
                            w_buf_n[Z_WIDTH*w +: Z_WIDTH] = w_word;
                        end
                    end
                    w_wcnt_n = r_wcnt + CNT_W'(1);
                    if (bus.DATA_LAST) begin
                        if (w_total == BCNT_W'(BYTES)) begin
                            // Message ends on a block boundary: pad goes in a block of its own.
                            w_state_n       = S_SEND;
                            w_last_flag_n   = 1'b0;
                            w_pad_pending_n = 1'b1;
                        end else begin
                            w_state_n = S_PAD;
                            w_bcnt_n  = w_total;
                        end
                    end else if (r_wcnt == CNT_W'(WORDS - 1)) begin
                        w_state_n     = S_SEND;
                        w_last_flag_n = 1'b0;
                    end
                end
            end
            S_PAD: begin
                w_buf_n       = w_padded;
                w_last_flag_n = 1'b1;
                w_state_n     = S_SEND;
            end
            S_SEND: begin
                if (bus.PERM_READY) begin
                    w_buf_n  = '0;
                    w_wcnt_n = '0;
                    w_bcnt_n = '0;
                    if (r_pad_pending) begin
                        w_pad_pending_n = 1'b0;
                        w_state_n       = S_PAD;
                    end else begin
                        w_state_n = S_FILL;
                    end
                end
            end
            default: w_state_n = S_FILL;
        endcase
    end

    // State register; CE freezes everything, reset overrides CE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_FILL;
            r_wcnt        <= '0;
            r_bcnt        <= '0;
            r_buf         <= '0;
            r_pad_pending <= 1'b0;
            r_last_flag   <= 1'b0;
        end else if (CE) begin
            r_state       <= w_state_n;
            r_wcnt        <= w_wcnt_n;
            r_bcnt        <= w_bcnt_n;
            r_buf         <= w_buf_n;
            r_pad_pending <= w_pad_pending_n;
            r_last_flag   <= w_last_flag_n;
        end
    end

    assign bus.DATA_READY                 = w_ready;
    assign bus.OUT                        = RST ? '0 : r_buf;
    assign bus.VALID_MESSAGE_FROM_PADDING = w_strobe;
    assign bus.LAST_MESSAGE_FROM_PADDING  = w_strobe & r_last_flag;

endmodule

// File: tb/tb_sha3_padding_unit.sv
// Directed testbench for sha3_padding_unit at R=1152 (144-byte blocks).
module tb_sha3_padding_unit;
    import sha3_pkg::*;

    localparam int unsigned R     = RATE_SHA3_224;
    localparam int unsigned BYTES = R / 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE  = 1'b1;

    sha3_padding_unit_if #(.R_BLOCK_SIZE(R)) bus ();

    sha3_padding_unit #(.R_BLOCK_SIZE(R)) dut (
        .CLK (CLK),
        .RST (RST),
        .CE  (CE),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_last_wo_valid = 0;
    int t_last = 0;
    bit ce_tog = 1'b0;

    logic [R-1:0] q_blk[$];
    logic         q_last[$];
    int           q_cyc[$];
    logic [R-1:0] abc_blk;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) CE = ce_tog ? ~CE : 1'b1;

    // Record every strobe; note any LAST without VALID.
    always @(negedge CLK) begin
        #2;
        if (bus.VALID_MESSAGE_FROM_PADDING === 1'b1) begin
            q_blk.push_back(bus.OUT);
            q_last.push_back(bus.LAST_MESSAGE_FROM_PADDING);
            q_cyc.push_back(cyc);
        end else if (bus.LAST_MESSAGE_FROM_PADDING !== 1'b0) begin
            n_last_wo_valid++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] msg_word(input int w);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = 8'(8*w + b + 1);
        return v;
    endfunction

    function automatic int first_diff(input logic [R-1:0] a, input logic [R-1:0] b);
        int d;
        d = 0;
        for (int k = int'(BYTES) - 1; k >= 0; k--) if (a[8*k +: 8] !== b[8*k +: 8]) d = k;
        return d;
    endfunction

    task automatic clear_q();
        q_blk.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            bus.DATA_IN = d;
            bus.DATA_VALID = 1'b1;
            bus.DATA_LAST = last;
            bus.DATA_NBYTES = nb;
            #1;
            if (bus.DATA_READY === 1'b1) begin
                done = 1'b1;
                t_last = cyc;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_word_timeout: DATA_READY got %b required 1", bus.DATA_READY);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drop_valid();
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        bus.DATA_LAST = 1'b0;
        bus.DATA_NBYTES = 4'd0;
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 80 && q_blk.size() < n; i++) @(negedge CLK);
        repeat (8) @(negedge CLK);
    endtask

    task automatic send_144(input logic [3:0] nb);
        for (int w = 0; w < 17; w++) send_word(msg_word(w), 1'b0, 4'd0);
        send_word(msg_word(17), 1'b1, nb);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        #1;
        checks++; if (bus.DATA_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", bus.DATA_READY); end
        checks++; if (bus.VALID_MESSAGE_FROM_PADDING !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.VALID_MESSAGE_FROM_PADDING); end
        checks++; if (bus.LAST_MESSAGE_FROM_PADDING !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", bus.LAST_MESSAGE_FROM_PADDING); end
        checks++; if (bus.OUT !== '0) begin errors++; $display("FAIL rst_out: byte %0d nonzero", first_diff(bus.OUT, '0)); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if (bus.DATA_READY !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b required 1", bus.DATA_READY); end
        checks++; if (bus.OUT !== '0) begin errors++; $display("FAIL post_rst_out: byte %0d nonzero", first_diff(bus.OUT, '0)); end
    endtask

    task automatic test_empty();
        logic [R-1:0] exp, got;
        int d;
        clear_q();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        drop_valid();
        wait_strobes(1);
        exp = '0;
        exp[7:0] = 8'h06;
        exp[R-1 -: 8] = 8'h80;
        checks++; if (q_blk.size() != 1) begin errors++; $display("FAIL empty_count: got %0d required 1", q_blk.size()); end
        if (q_blk.size() >= 1) begin
            got = q_blk[0];
            checks++; if (got !== exp) begin errors++; d = first_diff(got, exp); $display("FAIL empty_blk: byte %0d got %h required %h", d, got[8*d +: 8], exp[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL empty_last: got %b required 1", q_last[0]); end
            checks++; if (q_cyc[0] - t_last != 2) begin errors++; $display("FAIL empty_latency: got %0d required 2", q_cyc[0] - t_last); end
        end
    endtask

    task automatic test_abc();
        logic [R-1:0] exp, got;
        int d;
        clear_q();
        send_word(64'hDEAD_BEEF_FF63_6261, 1'b1, 4'd3);
        drop_valid();
        wait_strobes(1);
        exp = '0;
        exp[7:0]   = 8'h61;
        exp[15:8]  = 8'h62;
        exp[23:16] = 8'h63;
        exp[31:24] = 8'h06;
        exp[R-1 -: 8] = 8'h80;
        abc_blk = exp;
        checks++; if (q_blk.size() != 1) begin errors++; $display("FAIL abc_count: got %0d required 1", q_blk.size()); end
        if (q_blk.size() >= 1) begin
            got = q_blk[0];
            checks++; if (got !== exp) begin errors++; d = first_diff(got, exp); $display("FAIL abc_blk: byte %0d got %h required %h", d, got[8*d +: 8], exp[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL abc_last: got %b required 1", q_last[0]); end
            checks++; if (q_cyc[0] - t_last != 2) begin errors++; $display("FAIL abc_latency: got %0d required 2", q_cyc[0] - t_last); end
        end
    endtask

    task automatic test_143_bytes();
        logic [R-1:0] exp, got;
        logic [63:0] lw;
        int d;
        clear_q();
        for (int w = 0; w < 17; w++) send_word(msg_word(w), 1'b0, 4'd0);
        lw = msg_word(17);
        lw[63:56] = 8'hFF;
        send_word(lw, 1'b1, 4'd7);
        drop_valid();
        wait_strobes(1);
        exp = '0;
        for (int j = 0; j < 143; j++) exp[8*j +: 8] = 8'(j + 1);
        exp[8*143 +: 8] = 8'h86;
        checks++; if (q_blk.size() != 1) begin errors++; $display("FAIL m143_count: got %0d required 1", q_blk.size()); end
        if (q_blk.size() >= 1) begin
            got = q_blk[0];
            checks++; if (got !== exp) begin errors++; d = first_diff(got, exp); $display("FAIL m143_blk: byte %0d got %h required %h", d, got[8*d +: 8], exp[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL m143_last: got %b required 1", q_last[0]); end
            checks++; if (q_cyc[0] - t_last != 2) begin errors++; $display("FAIL m143_latency: got %0d required 2", q_cyc[0] - t_last); end
        end
    endtask

    task automatic test_full_boundary(input bit with_ce);
        logic [R-1:0] exp_d, exp_p, got;
        int d;
        clear_q();
        ce_tog = with_ce;
        send_144(with_ce ? 4'd15 : 4'd8);
        drop_valid();
        wait_strobes(2);
        ce_tog = 1'b0;
        exp_d = '0;
        for (int j = 0; j < 144; j++) exp_d[8*j +: 8] = 8'(j + 1);
        exp_p = '0;
        exp_p[7:0] = 8'h06;
        exp_p[R-1 -: 8] = 8'h80;
        checks++; if (q_blk.size() != 2) begin errors++; $display("FAIL m144_count ce=%0d: got %0d required 2", with_ce, q_blk.size()); end
        if (q_blk.size() >= 2) begin
            got = q_blk[0];
            checks++; if (got !== exp_d) begin errors++; d = first_diff(got, exp_d); $display("FAIL m144_data_blk ce=%0d: byte %0d got %h required %h", with_ce, d, got[8*d +: 8], exp_d[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b0) begin errors++; $display("FAIL m144_data_last ce=%0d: got %b required 0", with_ce, q_last[0]); end
            got = q_blk[1];
            checks++; if (got !== exp_p) begin errors++; d = first_diff(got, exp_p); $display("FAIL m144_pad_blk ce=%0d: byte %0d got %h required %h", with_ce, d, got[8*d +: 8], exp_p[8*d +: 8]); end
            checks++; if (q_last[1] !== 1'b1) begin errors++; $display("FAIL m144_pad_last ce=%0d: got %b required 1", with_ce, q_last[1]); end
            if (!with_ce) begin
                checks++; if (q_cyc[0] - t_last != 1) begin errors++; $display("FAIL m144_latency: got %0d required 1", q_cyc[0] - t_last); end
                checks++; if (q_cyc[1] - q_cyc[0] != 2) begin errors++; $display("FAIL m144_gap: got %0d required 2", q_cyc[1] - q_cyc[0]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [R-1:0] exp_d, exp_p, got;
        int d;
        clear_q();
        bus.PERM_READY = 1'b0;
        for (int w = 0; w < 18; w++) send_word(msg_word(w), 1'b0, 4'd0);
        exp_d = '0;
        for (int j = 0; j < 144; j++) exp_d[8*j +: 8] = 8'(j + 1);
        drop_valid();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            checks++; if (bus.VALID_MESSAGE_FROM_PADDING !== 1'b0) begin errors++; $display("FAIL bp_valid cyc%0d: got %b required 0", i, bus.VALID_MESSAGE_FROM_PADDING); end
            checks++; if (bus.DATA_READY !== 1'b0) begin errors++; $display("FAIL bp_ready cyc%0d: got %b required 0", i, bus.DATA_READY); end
            got = bus.OUT;
            checks++; if (got !== exp_d) begin errors++; d = first_diff(got, exp_d); $display("FAIL bp_out cyc%0d: byte %0d got %h required %h", i, d, got[8*d +: 8], exp_d[8*d +: 8]); end
        end
        @(negedge CLK);
        bus.PERM_READY = 1'b1;
        #1;
        checks++; if (bus.VALID_MESSAGE_FROM_PADDING !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b required 1", bus.VALID_MESSAGE_FROM_PADDING); end
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        drop_valid();
        wait_strobes(2);
        exp_p = '0;
        exp_p[7:0] = 8'h06;
        exp_p[R-1 -: 8] = 8'h80;
        checks++; if (q_blk.size() != 2) begin errors++; $display("FAIL bp_count: got %0d required 2", q_blk.size()); end
        if (q_blk.size() >= 2) begin
            got = q_blk[0];
            checks++; if (got !== exp_d) begin errors++; d = first_diff(got, exp_d); $display("FAIL bp_data_blk: byte %0d got %h required %h", d, got[8*d +: 8], exp_d[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b0) begin errors++; $display("FAIL bp_data_last: got %b required 0", q_last[0]); end
            got = q_blk[1];
            checks++; if (got !== exp_p) begin errors++; d = first_diff(got, exp_p); $display("FAIL bp_tail_blk: byte %0d got %h required %h", d, got[8*d +: 8], exp_p[8*d +: 8]); end
            checks++; if (q_last[1] !== 1'b1) begin errors++; $display("FAIL bp_tail_last: got %b required 1", q_last[1]); end
        end
    endtask

    task automatic test_reset_mid_message();
        logic [R-1:0] got;
        int d;
        clear_q();
        for (int w = 0; w < 5; w++) send_word(msg_word(w), 1'b0, 4'd0);
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        #1;
        checks++; if (bus.DATA_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", bus.DATA_READY); end
        checks++; if (bus.OUT !== '0) begin errors++; $display("FAIL mid_rst_out: byte %0d nonzero", first_diff(bus.OUT, '0)); end
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (q_blk.size() != 0) begin errors++; $display("FAIL mid_rst_no_strobe: got %0d strobes required 0", q_blk.size()); end
        send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        drop_valid();
        wait_strobes(1);
        checks++; if (q_blk.size() != 1) begin errors++; $display("FAIL mid_rst_abc_count: got %0d required 1", q_blk.size()); end
        if (q_blk.size() >= 1) begin
            got = q_blk[0];
            checks++; if (got !== abc_blk) begin errors++; d = first_diff(got, abc_blk); $display("FAIL mid_rst_abc_blk: byte %0d got %h required %h", d, got[8*d +: 8], abc_blk[8*d +: 8]); end
            checks++; if (q_last[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_abc_last: got %b required 1", q_last[0]); end
        end
    endtask

    task automatic test_last_qualified();
        checks++;
        if (n_last_wo_valid != 0) begin
            errors++;
            $display("FAIL last_without_valid: got %0d cycles required 0", n_last_wo_valid);
        end
    endtask

    initial begin
        bus.DATA_IN = '0;
        bus.DATA_VALID = 1'b0;
        bus.DATA_LAST = 1'b0;
        bus.DATA_NBYTES = 4'd0;
        bus.PERM_READY = 1'b1;
        abc_blk = '0;
        test_reset();
        test_empty();
        test_abc();
        test_143_bytes();
        test_full_boundary(1'b0);
        test_backpressure();
        test_reset_mid_message();
        test_full_boundary(1'b1);
        test_last_qualified();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_padding_unit.md
Name: sha3_padding_unit

Overview:
- Upstream producer for the Keccak permutation block. It accepts the message as a 64-bit word stream with a valid/ready handshake and packs the words into R_BLOCK_SIZE-bit rate blocks.
- It applies SHA-3 padding: domain byte 0x06 goes in the first free byte, 0x80 is OR'd into the last byte of the block.
- Each block is handed over with a one-cycle VALID_MESSAGE_FROM_PADDING strobe. LAST_MESSAGE_FROM_PADDING marks the final block of a message.

Parameters:
- R_BLOCK_SIZE, 1152, rate in bits. Must be a multiple of 64. Legal values: 1152, 1088, 832, 576.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- CE  in  1  clock enable. All state and handshakes are frozen while CE=0.
- DATA_IN  in  64  message word. DATA_IN[0:7] is the first byte in message order.
- DATA_VALID  in  1  DATA_IN is valid.
- DATA_LAST  in  1  current word is the final word of the message.
- DATA_NBYTES  in  4  valid bytes in a DATA_LAST word, 0..8, leading bytes. Ignored when DATA_LAST=0 (word treated as 8 bytes). Values above 8 are treated as 8.
- DATA_READY  out  1  unit can accept a word.
- PERM_READY  in  1  permutation is waiting for a new block.
- OUT  out  R_BLOCK_SIZE  rate block, bits [0:R_BLOCK_SIZE-1]. Byte k occupies OUT[8k:8k+7].
- VALID_MESSAGE_FROM_PADDING  out  1  one-cycle block strobe.
- LAST_MESSAGE_FROM_PADDING  out  1  qualifies the strobe: final block of the message.

Behaviour:
- Reset sync and active-high, fixed. Clock is CLK, reset is RST. During the RST cycle and after it:
  - state = S_FILL, word counter = 0, block buffer = 0, pad_pending = 0.
  - OUT = 0, VALID and LAST = 0.
  - DATA_READY = 0 while RST is high, 1 in the first cycle after.
- RST mid-operation drops the partial message and any pending block without emitting a strobe.
- Word transfer happens on CE & DATA_VALID & DATA_READY.
- DATA_READY = CE & (state == S_FILL).
- States:
  - S_FILL:
    - Each transfer writes DATA_IN to word slot wcnt, and wcnt increments.
    - Non-last word completing the block (wcnt = WORDS-1, WORDS = R_BLOCK_SIZE/64): go to S_SEND with last_flag=0.
    - DATA_LAST word with total bytes in block < R/8: masks invalid bytes to 0, goes to S_PAD.
    - DATA_LAST word filling the block exactly: go to S_SEND with last_flag=0 and pad_pending=1.
  - S_PAD (one cycle):
    - XOR 0x06 into byte index b = valid byte count of the block (0 when the block is empty).
    - OR 0x80 into byte R/8-1. When b = R/8-1 that byte becomes 0x86.
    - Set last_flag=1, then go to S_SEND.
  - S_SEND:
    - OUT holds the buffer.
    - When CE & PERM_READY, assert VALID=1 and LAST=last_flag for exactly that cycle.
    - Next cycle: buffer = 0 and wcnt = 0. Go to S_PAD if pad_pending (clearing it), else to S_FILL.
    - While PERM_READY=0, VALID stays 0 indefinitely and OUT is stable.
- LAST=0 whenever VALID=0.
- OUT is only meaningful while VALID=1. Between strobes OUT shows the buffer being filled.
- Latency:
  - Word completing a block at cycle t: earliest strobe at t+1.
  - Final partial word at t: S_PAD at t+1, earliest strobe at t+2.
  - Full-boundary final word: data block strobe at t+1 or later, then the extra pad-only block (0x06 at byte 0, 0x80 at byte R/8-1) at least 2 cycles after that.
- Empty message is one beat with DATA_LAST=1 and DATA_NBYTES=0. It produces a single padded block with LAST=1.
- CE=0 freezes state, counters and buffer, and forces VALID=0 and DATA_READY=0.

Decomposition:
- Package sha3_pkg holds:
  - STATE_SIZE=1600, Z_WIDTH=64.
  - Rate constants for SHA3-224/256/384/512.
  - SHA3_DOMAIN_BYTE=8'h06, SHA3_FINAL_BYTE=8'h80.
  - pad_state_t enum {S_FILL, S_PAD, S_SEND}.
- One combinational sub-module, sha3_pad_inserter. Inputs: block, byte count. Output: padded block. Keeps the byte-index arithmetic out of the FSM.

Test Plan:
- Empty message, R=1152 -> one strobe, LAST=1, byte0=0x06, byte143=0x80, all other bytes 0.
- "abc" as one beat (DATA_IN[0:23]=0x616263, NBYTES=3) -> strobe 2 cycles after transfer, bytes 0..3 = 61 62 63 06, byte143=0x80, LAST=1.
- 143-byte message (17 full words + NBYTES=7) -> single block, byte142 = message byte, byte143=0x86, LAST=1.
- 144-byte message, R=1152 -> two strobes: first is the data block with LAST=0, second is pad-only (byte0=0x06, byte143=0x80) with LAST=1.
- PERM_READY held low 10 cycles with a full block pending -> no strobe, DATA_READY=0, OUT stable. Strobe in the first cycle PERM_READY=1.
- RST asserted after 5 words of a message -> no strobe. Next message "abc" yields the same block as the "abc" test. Repeat the 144-byte test with CE toggling every other cycle -> identical blocks and strobe order.
